// File: rtl/sol32_data_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sol32_data_pkg
// Purpose  : Shared types and helpers for the sol32 data port: access-width
//            encodings, the port FSM state type, access size decode and
//            byte-lane mask generation.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package sol32_data_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SECOND = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Access size in bytes; 0 for the reserved encoding.
  function automatic logic [2:0] size_of(input logic [1:0] width);
    logic [2:0] sz;
    case (width)
      WIDTH_BYTE: sz = 3'd1;
      WIDTH_HALF: sz = 3'd2;
      WIDTH_WORD: sz = 3'd4;
      default:    sz = 3'd0;
    endcase
    return sz;
  endfunction

  // Lanes over a two-word window: [3:0] belong to the addressed word,
  // [7:4] spill into the following word for word-crossing accesses.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] size);
    logic [7:0] base;
    case (size)
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      3'd4:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sol32_data_ram.sv
`default_nettype none
// ============================================================================
// Module   : sol32_data_ram
// Purpose  : Single-port DEPTH_WORDS x 32 data RAM with per-byte write
//            enables and a one-cycle synchronous read. Contents are never
//            reset.
// Ports    : clk_i    - clock
//            en_i     - access enable (read always performed when enabled)
//            we_i     - byte write enables, lane 0 = bits [7:0]
//            addr_i   - word index
//            wdata_i  - write data
//            rdata_o  - read data, valid the cycle after en_i
// Revision : 1.0 - initial release
// ============================================================================
module sol32_data_ram #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [3:0]        we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Read returns the pre-write contents when reading and writing together.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sol32_data_port.sv
`default_nettype none
// ============================================================================
// Module   : sol32_data_port
// Purpose  : Data-bus responder for the sol32 core. Decodes byte/half/word
//            little-endian accesses, splits word-crossing accesses into two
//            RAM cycles, and answers with a one-cycle Ready (optionally
//            qualified by Fault) carrying zero-extended load data.
// Ports    : Clock, Reset         - clock, async active-high reset
//            ReadEnable/WriteEnable - load/store request
//            DataWidth            - 00 byte, 01 half, 10 word, 11 reserved
//            MemoryAddress        - byte address
//            DataOut              - store data (right-justified)
//            DataIn               - load data (right-justified, zero-extended)
//            Ready                - access complete pulse
//            Fault                - access rejected, qualifies Ready
// Revision : 1.0 - initial release
// ============================================================================
module sol32_data_port
  import sol32_data_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [1:0]  DataWidth,
  input  logic [31:0] MemoryAddress,
  input  logic [31:0] DataOut,
  output logic [31:0] DataIn,
  output logic        Ready,
  output logic        Fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  // Acceptance-time decode
  logic          req_w;
  logic [1:0]    off_w;
  logic [2:0]    size_w;
  logic [29:0]   relw_w;
  logic [AW-1:0] idx_w;
  logic          split_w;
  logic          fault_w;
  logic [7:0]    lanes_w;
  logic [63:0]   wdata_w;

  assign req_w   = ReadEnable | WriteEnable;
  assign off_w   = MemoryAddress[1:0];
  assign size_w  = size_of(DataWidth);
  // BASE_ADDR is window aligned, so word-granular subtraction suffices;
  // addresses below the base wrap to large values and fail the range test.
  assign relw_w  = MemoryAddress[31:2] - BASE_ADDR[31:2];
  assign idx_w   = relw_w[AW-1:0];
  assign split_w = (3'(off_w) + size_w) > 3'd4;
  assign fault_w = (DataWidth == WIDTH_RSVD)
                 | (ReadEnable & WriteEnable)
                 | (relw_w[29:AW] != '0)
                 | (split_w & (idx_w == '1));
  assign lanes_w = lane_mask(off_w, size_w);
  assign wdata_w = 64'(DataOut) << {off_w, 3'b000};

  // Registered state
  state_t        state_q;
  logic          ready_q, fault_q, load_q, store_q, split_q;
  logic [1:0]    off_q;
  logic [2:0]    size_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    lanes_hi_q;
  logic [31:0]   wdata_hi_q;
  logic [31:0]   lo_q;

  // RAM interface
  logic          ram_en_d;
  logic [3:0]    ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [31:0]   ram_wdata_d;
  logic [31:0]   ram_rdata;

  // The RAM is driven in the acceptance cycle so a non-split read lands in
  // the response cycle without an extra stage.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = idx_w;
    ram_wdata_d = wdata_w[31:0];
    case (state_q)
      ST_IDLE: begin
        if (req_w && !fault_w) begin
          ram_en_d = 1'b1;
          ram_we_d = WriteEnable ? lanes_w[3:0] : 4'b0000;
        end
      end
      ST_SECOND: begin
        ram_en_d    = 1'b1;
        ram_addr_d  = idx_q + AW'(1);
        ram_we_d    = store_q ? lanes_hi_q : 4'b0000;
        ram_wdata_d = wdata_hi_q;
      end
      default: ;
    endcase
  end

  sol32_data_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_ram (
    .clk_i   (Clock),
    .en_i    (ram_en_d),
    .we_i    (ram_we_d),
    .addr_i  (ram_addr_d),
    .wdata_i (ram_wdata_d),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      split_q    <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 3'd0;
      idx_q      <= '0;
      lanes_hi_q <= 4'b0000;
      wdata_hi_q <= 32'h0;
      lo_q       <= 32'h0;
    end else begin
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_w) begin
            off_q      <= off_w;
            size_q     <= size_w;
            idx_q      <= idx_w;
            load_q     <= ReadEnable & ~fault_w;
            store_q    <= WriteEnable & ~fault_w;
            lanes_hi_q <= lanes_w[7:4];
            wdata_hi_q <= wdata_w[63:32];
            if (split_w && !fault_w) begin
              split_q <= 1'b1;
              state_q <= ST_SECOND;
            end else begin
              split_q <= 1'b0;
              ready_q <= 1'b1;
              fault_q <= fault_w;
              state_q <= ST_RESP;
            end
          end
        end
        ST_SECOND: begin
          lo_q    <= ram_rdata;  // first word read issued at acceptance
          ready_q <= 1'b1;
          state_q <= ST_RESP;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Load assembly: the high word's bytes sit above the low word's bytes.
  logic [63:0] word64_w;
  logic [31:0] raw_w;
  logic [31:0] mask_w;

  assign word64_w = split_q ? {ram_rdata, lo_q} : {32'h0, ram_rdata};
  assign raw_w    = 32'(word64_w >> {off_q, 3'b000});

  always_comb begin
    mask_w = 32'hFFFF_FFFF;
    case (size_q)
      3'd1:    mask_w = 32'h0000_00FF;
      3'd2:    mask_w = 32'h0000_FFFF;
      default: mask_w = 32'hFFFF_FFFF;
    endcase
  end

  assign DataIn = (ready_q && load_q) ? (raw_w & mask_w) : 32'h0;
  assign Ready  = ready_q;
  assign Fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_sol32_data_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sol32_data_port
// Purpose  : Directed and back-to-back random checks of sol32_data_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sol32_data_port;

  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  dw = 2'b00;
  logic [31:0] addr = 32'h0;
  logic [31:0] dout = 32'h0;
  logic [31:0] din;
  logic        rdy;
  logic        flt;

  int checks = 0;
  int errors = 0;

  logic [7:0] model [64];

  sol32_data_port #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .Clock         (clk),
    .Reset         (rst),
    .ReadEnable    (re),
    .WriteEnable   (we),
    .DataWidth     (dw),
    .MemoryAddress (addr),
    .DataOut       (dout),
    .DataIn        (din),
    .Ready         (rdy),
    .Fault         (flt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request at a falling edge and waits (bounded) for Ready.
  task automatic access(input logic r, input logic w, input logic [1:0] width,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] data, output logic f, output int cyc);
    re = r; we = w; dw = width; addr = a; dout = d;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rdy && cyc < 8);
    data = din;
    f    = flt;
  endtask

  task automatic idle();
    re = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic dir(input string tag, input logic r, input logic w, input logic [1:0] width,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_data, input logic exp_fault, input int exp_cyc);
    logic [31:0] data;
    logic        f;
    int          cyc;
    idle();
    access(r, w, width, a, d, data, f, cyc);
    chk({tag, "_data"}, data, exp_data);
    chk({tag, "_fault"}, {31'h0, f}, {31'h0, exp_fault});
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    logic [31:0] data, v, expv;
    logic        f;
    int          cyc, wi, off, sz;
    logic        isld;
    logic [1:0]  width;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, rdy}, 32'h0);
    chk("rst_fault", {31'h0, flt}, 32'h0);
    chk("rst_datain", din, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned word, byte merge, half load
    dir("st_w",   1'b0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    dir("ld_w",   1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    dir("st_w2",  1'b0, 1'b1, 2'b10, 32'h10, 32'h1122_3344, 32'h0, 1'b0, 1);
    dir("st_b",   1'b0, 1'b1, 2'b00, 32'h13, 32'h1234_56A5, 32'h0, 1'b0, 1);
    dir("ld_wb",  1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'hA522_3344, 1'b0, 1);
    dir("ld_b",   1'b1, 1'b0, 2'b00, 32'h13, 32'h0, 32'h0000_00A5, 1'b0, 1);
    dir("ld_h",   1'b1, 1'b0, 2'b01, 32'h12, 32'h0, 32'h0000_A522, 1'b0, 1);

    // Word-crossing store and loads
    dir("st_0c",  1'b0, 1'b1, 2'b10, 32'h0C, 32'h0102_0304, 32'h0, 1'b0, 1);
    dir("st_10",  1'b0, 1'b1, 2'b10, 32'h10, 32'h0506_0708, 32'h0, 1'b0, 1);
    dir("st_spl", 1'b0, 1'b1, 2'b10, 32'h0E, 32'hCAFE_F00D, 32'h0, 1'b0, 2);
    dir("ld_lo",  1'b1, 1'b0, 2'b10, 32'h0C, 32'h0, 32'hF00D_0304, 1'b0, 1);
    dir("ld_hi",  1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'h0506_CAFE, 1'b0, 1);
    dir("ld_spl", 1'b1, 1'b0, 2'b10, 32'h0E, 32'h0, 32'hCAFE_F00D, 1'b0, 2);
    dir("ld_sph", 1'b1, 1'b0, 2'b01, 32'h0F, 32'h0, 32'h0000_FEF0, 1'b0, 2);

    // Faults
    dir("st_last",  1'b0, 1'b1, 2'b10, 32'hFC, 32'h5566_7788, 32'h0, 1'b0, 1);
    dir("flt_rsvd", 1'b1, 1'b0, 2'b11, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    dir("flt_rewe", 1'b1, 1'b1, 2'b10, 32'h10, 32'h9999_9999, 32'h0, 1'b1, 1);
    dir("ld_nowr",  1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'h0506_CAFE, 1'b0, 1);
    dir("flt_rng",  1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 32'h0, 1'b1, 1);
    dir("flt_wrap", 1'b0, 1'b1, 2'b10, 32'hFE, 32'hAAAA_AAAA, 32'h0, 1'b1, 1);
    dir("ld_last",  1'b1, 1'b0, 2'b10, 32'hFC, 32'h0, 32'h5566_7788, 1'b0, 1);

    // Reset while a split load is in its second cycle
    idle();
    re = 1'b1; we = 1'b0; dw = 2'b10; addr = 32'h0E;
    @(negedge clk);
    rst = 1'b1; re = 1'b0;
    @(negedge clk);
    chk("rstmid_rdy1", {31'h0, rdy}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rdy2", {31'h0, rdy}, 32'h0);
    dir("ld_after_rst", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0, 32'h0506_CAFE, 1'b0, 1);

    // Back-to-back: each request is presented in the Ready cycle of the
    // previous one, so every access takes exactly two cycles end to end.
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      access(1'b0, 1'b1, 2'b10, 32'(i * 4), v, data, f, cyc);
      for (int k = 0; k < 4; k++) model[i*4 + k] = v[8*k +: 8];
      chk("b2b_init_lat", 32'(cyc), 32'd2);
    end
    for (int n = 0; n < 100; n++) begin
      isld  = 1'($urandom_range(0, 1));
      width = 2'($urandom_range(0, 2));
      wi    = int'($urandom_range(0, 15));
      case (width)
        2'b00:   begin sz = 1; off = int'($urandom_range(0, 3)); end
        2'b01:   begin sz = 2; off = 2 * int'($urandom_range(0, 1)); end
        default: begin sz = 4; off = 0; end
      endcase
      v    = $urandom;
      expv = 32'h0;
      if (isld) begin
        for (int k = 0; k < sz; k++) expv[8*k +: 8] = model[wi*4 + off + k];
      end else begin
        for (int k = 0; k < sz; k++) model[wi*4 + off + k] = v[8*k +: 8];
      end
      access(isld, ~isld, width, 32'(wi * 4 + off), v, data, f, cyc);
      chk("b2b_data", data, expv);
      chk("b2b_fault", {31'h0, f}, 32'h0);
      chk("b2b_lat", 32'(cyc), 32'd2);
    end

    // Only one Ready per access: the cycle after the last one is idle.
    re = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("b2b_no_dup", {31'h0, rdy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sol32_data_port.md
Name: sol32_data_port

Overview:
- Responder for the sol32 core's data bus. Serves core loads and stores against an internal word-organised RAM.
- Decodes the access width, generates byte lanes for little-endian layout, and splits misaligned word-crossing accesses into two RAM cycles.
- Returns load data and a one-cycle Ready strobe. Sits between the core's data port and the data RAM.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the RAM; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- Clock  in  1  core clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReadEnable  in  1  load request from core.
- WriteEnable  in  1  store request from core.
- DataWidth  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- MemoryAddress  in  32  byte address.
- DataOut  in  32  store data from core, right-justified.
- DataIn  out  32  load data to core, right-justified, zero-extended.
- Ready  out  1  one-cycle pulse: access complete, DataIn valid for loads.
- Fault  out  1  qualifies Ready: access rejected, no RAM write performed.

Behaviour:
- Reset (async, any state): state=IDLE, Ready=0, Fault=0, DataIn=0, capture registers=0. RAM contents are not cleared.
- Request sampling:
  - A request is ReadEnable|WriteEnable sampled in IDLE only.
  - The core holds all request inputs stable until the cycle Ready=1.
  - Inputs are ignored outside IDLE.
- Decode at acceptance:
  - off=addr[1:0]; size=1/2/4 bytes for width 00/01/10.
  - idx=(addr-BASE_ADDR)>>2.
  - split = off+size>4.
- Fault conditions, checked up front with no partial access:
  - width=11;
  - ReadEnable&WriteEnable;
  - addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS);
  - split and idx+1==DEPTH_WORDS (no wrap to word 0).
  - Faulted request: go to RESP, Ready=1 with Fault=1 and DataIn=0 in the next cycle; RAM untouched.
- FSM states: IDLE, SECOND, RESP.
  - IDLE, valid non-split request: RAM op on idx, with byte enables = size mask << off and write data = DataOut << 8*off. Next state RESP.
  - IDLE, valid split request:
    - first op on idx with lanes off..3;
    - next state SECOND, latching request fields and the low store bytes already consumed.
  - SECOND: RAM op on idx+1 with lanes 0..(off+size-5); store data is the remaining high bytes of DataOut. First-word read data is captured. Next state RESP.
  - RESP: Ready=1 for exactly one cycle; DataIn holds assembled load data; then IDLE.
- Latency and throughput:
  - Non-split access: Ready in cycle N+1 after acceptance in N.
  - Split access: Ready in N+2.
  - A new request can be accepted in the cycle after Ready, so aligned throughput is 1 access per 2 cycles.
- RAM is synchronous-read, 1-cycle latency; read and write in the same cycle never target the same access.
- Load assembly:
  - bytes extracted from word(s) >> 8*off;
  - the split case concatenates the high word's low bytes above the low word's high bytes;
  - masked to size and zero-extended.
- Stores: DataIn=0 at Ready.
- Reset asserted mid-access: FSM returns to IDLE immediately and no Ready is issued. A first-half split store may already be committed; this is accepted and documented.
- DataIn and Fault are registered and hold their values only while Ready=1; they are 0 otherwise.

Decomposition:
- Package sol32_data_pkg:
  - width encodings WIDTH_BYTE/HALF/WORD/RSVD;
  - state enum {IDLE, SECOND, RESP};
  - function size_of(width);
  - function lane_mask(off, size).
- Sub-module sol32_data_ram: single-port DEPTH_WORDS x 32 RAM with 4-bit byte write enable and synchronous read, instantiated once.

Test Plan:
- Word store 32'hDEADBEEF @0x10, then word load @0x10 -> store Ready at N+1 with Fault=0; load Ready at N+1 with DataIn=32'hDEADBEEF.
- Byte store 8'hA5 @0x13 over word 0x11223344, then word load @0x10 -> DataIn=32'hA5223344; byte load @0x13 -> DataIn=32'h000000A5.
- Split word store 32'hCAFEF00D @0x0E, then loads @0x0C and @0x10 -> 32'hF00D_xxxx (upper half) and 32'hxxxx_CAFE (lower half), other bytes unchanged; split load @0x0E -> DataIn=32'hCAFEF00D with Ready at N+2.
- Faults:
  - width=11 -> Ready with Fault=1, DataIn=0;
  - RE&WE together -> Fault=1;
  - address 4*DEPTH_WORDS -> Fault=1;
  - word access at 4*DEPTH_WORDS-2 -> Fault=1, last word unchanged.
- Reset pulse asserted in SECOND of a split load -> no Ready; IDLE next cycle; a subsequent aligned load completes normally at N+1.
- Back-to-back: load accepted the cycle after Ready -> no dropped or duplicated Ready over 100 random aligned accesses compared against a scoreboard model.
